// File: rtl/rb_fifo_pkg.sv
// rb_fifo_pkg: shared state type, default sizes and level-width helper for rb_fifo_sched
package rb_fifo_pkg;
  typedef enum logic {FLUSH, RUN} state_t;
  localparam int DEF_MSBD = 1;
  localparam int DEF_LAST = 3;
  localparam int DEF_MSBA = 1;
  function automatic int lvl_w(input int msba);
    return msba + 2;
  endfunction
endpackage

// File: rtl/rb_fifo_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1 with wrap
module rr_arbiter #(
  parameter int NREQ = 3,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   winner
);
  int idx;
  logic found;
  always_comb begin
    gnt = '0;
    winner = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        winner = PW'(idx);
      end
    end
    gnt[winner] = en & found;
  end
endmodule

// File: rtl/rb_fifo_sched.sv
// rb_fifo_sched: round-robin push sharing and pop scheduling in front of a reset-less ring buffer;
// never issues push and pop together, and drains the buffer after reset or on flush.
module rb_fifo_sched
  import rb_fifo_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int MSBD = DEF_MSBD,
  parameter int LAST = DEF_LAST,
  parameter int MSBA = DEF_MSBA
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*(MSBD+1)-1:0] req_data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     pop_req,
  output logic                     pop_ack,
  output logic [MSBD:0]            pop_data,
  input  logic                     flush,
  output logic                     busy,
  output logic [lvl_w(MSBA)-1:0]   level,
  output logic                     fifo_push,
  output logic                     fifo_pop,
  output logic [MSBD:0]            fifo_data_in,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  input  logic [MSBD:0]            fifo_data_out
);
  localparam int PW = $clog2(NREQ);
  localparam int LW = lvl_w(MSBA);
  localparam int DW = MSBD + 1;
  if (LAST + 1 != 2 ** (MSBA + 1)) begin : g_bad_depth
    $error("rb_fifo_sched: LAST+1 must equal 2**(MSBA+1)");
  end
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, winner;
  logic turn, act, push_cand, pop_cand, do_push, do_pop;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .en     (do_push),
    .gnt    (gnt),
    .winner (winner)
  );
  // a flush request consumes its cycle, so no operation can slip past it
  always_comb begin
    act = reset_n & (state == RUN) & ~flush;
    push_cand = act & (|req) & ~fifo_full;
    pop_cand = act & pop_req & ~fifo_empty;
    do_push = push_cand & ~(pop_cand & turn);
    do_pop = pop_cand & ~do_push;
    state_nx = state == FLUSH ? (fifo_empty ? RUN : FLUSH) : (flush ? FLUSH : RUN);
  end
  assign fifo_push = do_push;
  assign fifo_pop = do_pop | (reset_n & (state == FLUSH) & ~fifo_empty);
  assign pop_ack = do_pop;
  assign pop_data = fifo_data_out;
  assign busy = state == FLUSH;
  assign fifo_data_in = do_push ? req_data[int'(winner)*DW +: DW] : '0;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= FLUSH;
      rr_ptr <= PW'(NREQ - 1);
      turn <= 1'b0;
      level <= '0;
    end else begin
      state <= state_nx;
      rr_ptr <= do_push ? winner : rr_ptr;
      turn <= turn ^ (push_cand & pop_cand);
      level <= (state == FLUSH || flush) ? '0 : level + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: tb/tb_rb_fifo_sched.sv
// tb_rb_fifo_sched: reference model + scoreboard bench driving rb_fifo_sched against a ring-buffer model
module tb_rb_fifo_sched;
  localparam int NREQ = 3;
  localparam int DW = 2;
  localparam int DEPTH = 4;
  localparam int LW = 3;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0] gnt;
  logic pop_req = 1'b0;
  logic pop_ack;
  logic [DW-1:0] pop_data;
  logic flush = 1'b0;
  logic busy;
  logic [LW-1:0] level;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_data_in, fifo_data_out;
  int checks = 0;
  int failures = 0;

  rb_fifo_sched #(.NREQ(NREQ), .MSBD(DW-1), .LAST(DEPTH-1), .MSBA(1)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data), .gnt(gnt),
    .pop_req(pop_req), .pop_ack(pop_ack), .pop_data(pop_data), .flush(flush),
    .busy(busy), .level(level), .fifo_push(fifo_push), .fifo_pop(fifo_pop),
    .fifo_data_in(fifo_data_in), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out)
  );

  always #5 clock = ~clock;

  // ring buffer with no reset, preloaded with 3 stale entries; push wins, a concurrent pop is dropped
  int bcnt = 3;
  int bwr = 3;
  int brd = 0;
  logic [DW-1:0] bmem [DEPTH] = '{2'd1, 2'd2, 2'd3, 2'd0};
  assign fifo_full = bcnt == DEPTH;
  assign fifo_empty = bcnt == 0;
  assign fifo_data_out = bmem[brd];
  always @(posedge clock) begin
    if (fifo_push && bcnt < DEPTH) begin
      bmem[bwr] <= fifo_data_in;
      bwr <= (bwr + 1) % DEPTH;
      bcnt <= bcnt + 1;
    end else if (fifo_pop && bcnt > 0) begin
      brd <= (brd + 1) % DEPTH;
      bcnt <= bcnt - 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: decides each cycle's operation from the scheduling rules
  logic [DW-1:0] exp_q[$];
  bit mrun = 0, mturn = 0, armed = 0;
  int rr = NREQ - 1;
  int mlev = 0;
  int w;
  bit pc, oc, epush, epop;
  logic [NREQ-1:0] eg;
  logic [DW-1:0] ed;
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_ack", int'(pop_ack), 0);
      chk("rst_push", int'(fifo_push), 0);
      chk("rst_pop", int'(fifo_pop), 0);
      mrun = 0; mturn = 0; rr = NREQ - 1; mlev = 0; armed = 1;
      exp_q.delete();
    end else if (armed) begin
      epush = 0; epop = 0; eg = '0; ed = '0;
      if (!mrun) begin
        chk("fl_busy", int'(busy), 1);
        chk("fl_level", int'(level), 0);
        chk("fl_gnt", int'(gnt), 0);
        chk("fl_ack", int'(pop_ack), 0);
        chk("fl_push", int'(fifo_push), 0);
        chk("fl_pop", int'(fifo_pop), int'(!fifo_empty));
        mrun = fifo_empty;
      end else begin
        chk("run_busy", int'(busy), 0);
        chk("level", int'(level), mlev);
        chk("gnt_onehot0", int'($onehot0(gnt)), 1);
        chk("level0_iff_empty", int'(level == 0), int'(fifo_empty));
        chk("levelmax_iff_full", int'(level == DEPTH), int'(fifo_full));
        if (flush) begin
          mrun = 0; mlev = 0;
          exp_q.delete();
        end else begin
          pc = (|req) && !fifo_full;
          oc = pop_req && !fifo_empty;
          if (pc && oc) begin
            epush = !mturn; epop = mturn; mturn = !mturn;
          end else begin
            epush = pc; epop = oc;
          end
          if (epush) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++)
              if (w < 0 && req[(rr + k) % NREQ]) w = (rr + k) % NREQ;
            eg[w] = 1'b1;
            ed = req_data[w*DW +: DW];
            exp_q.push_back(ed);
            rr = w;
            mlev++;
          end
          if (epop) mlev--;
        end
        chk("gnt", int'(gnt), int'(eg));
        chk("pop_ack", int'(pop_ack), int'(epop));
        chk("fifo_push", int'(fifo_push), int'(epush));
        chk("fifo_pop", int'(fifo_pop), int'(epop));
        chk("fifo_data_in", int'(fifo_data_in), int'(ed));
      end
    end
  end

  // monitor: every accepted pop must deliver the oldest expected entry
  logic [DW-1:0] got_exp;
  always @(negedge clock) begin
    if (reset_n && pop_ack) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
      else begin
        got_exp = exp_q.pop_front();
        chk("pop_data", int'(pop_data), int'(got_exp));
      end
    end
  end

  task automatic drive(input logic rn, input logic [NREQ-1:0] r, input logic p, input logic f, input int n);
    for (int i = 0; i < n; i++) begin
      reset_n = rn; req = r; pop_req = p; flush = f;
      req_data = (NREQ*DW)'($urandom);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    drive(0, 3'b000, 0, 0, 2);
    drive(1, 3'b000, 0, 0, 6);
    drive(1, 3'b111, 0, 0, 6);
    drive(1, 3'b000, 1, 0, 2);
    drive(1, 3'b001, 1, 0, 4);
    drive(1, 3'b001, 0, 0, 2);
    drive(1, 3'b010, 1, 0, 2);
    drive(1, 3'b000, 1, 0, 7);
    drive(1, 3'b100, 1, 0, 1);
    drive(1, 3'b000, 1, 0, 2);
    drive(1, 3'b001, 0, 0, 3);
    drive(1, 3'b001, 0, 1, 1);
    drive(1, 3'b000, 0, 0, 6);
    drive(1, 3'b111, 0, 0, 3);
    for (int i = 0; i < 2000; i++)
      drive(($urandom % 300) != 0, NREQ'($urandom), 1'($urandom), ($urandom % 50) == 0, 1);
    drive(1, 3'b000, 1, 0, 12);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_level", int'(level), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
